// File: rtl/shift_register_pkg.sv
// Shared definitions for the parametrised display shift register: operation
// codes, per-stage source select and the occupancy counter width.
package shift_register_pkg;

   localparam logic [2:0] MODE_HOLD  = 3'd0;
   localparam logic [2:0] MODE_SHL   = 3'd1;
   localparam logic [2:0] MODE_SHR   = 3'd2;
   localparam logic [2:0] MODE_ROL   = 3'd3;
   localparam logic [2:0] MODE_ROR   = 3'd4;
   localparam logic [2:0] MODE_LOAD  = 3'd5;
   localparam logic [2:0] MODE_CLEAR = 3'd6;

   typedef enum logic [2:0] {
      SEL_HOLD  = 3'd0,
      SEL_LEFT  = 3'd1,
      SEL_RIGHT = 3'd2,
      SEL_PAR   = 3'd3,
      SEL_ZERO  = 3'd4
   } sel_e;

   // Enough bits to hold every value from 0 up to and including depth.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One W-bit tap of the shift chain: holds, or loads the left neighbour, the
// right neighbour, its parallel word or zero.
module shift_stage
   import shift_register_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         en,
   input  logic [2:0]   sel,
   input  logic [W-1:0] left,
   input  logic [W-1:0] right,
   input  logic [W-1:0] par,
   output logic [W-1:0] q
);

   logic [W-1:0] nxt;

   always_comb begin
      // NOTE: assigning a default before the case keeps this purely combinational (no latch).
      nxt = q;
      case (sel_e'(sel))
         SEL_LEFT:  nxt = left;
         SEL_RIGHT: nxt = right;
         SEL_PAR:   nxt = par;
         SEL_ZERO:  nxt = '0;
         default:   nxt = q;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every tap samples its neighbour's old value.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         q <= '0;
      else if (en)
         q <= nxt;
   end

endmodule

// File: rtl/shift_register_param.sv
// DEPTH-word display shift register with bidirectional shift, rotate, parallel
// load, clear and occupancy count; every tap is exposed on Dout.
module shift_register_param
   import shift_register_pkg::*;
#(
   parameter int W     = 4,
   parameter int DEPTH = 8
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            Ce,
   input  logic [2:0]                      Mode,
   input  logic [W-1:0]                    Din,
   input  logic [W*DEPTH-1:0]              Pin,
   output logic [W*DEPTH-1:0]              Dout,
   output logic [W-1:0]                    Sout,
   output logic [count_width(DEPTH)-1:0]   Count,
   output logic                            Full,
   output logic                            Empty
);

   localparam int CW = count_width(DEPTH);

   logic [W-1:0] tap [DEPTH];
   logic [2:0]   sel;

   always_comb begin
      sel = SEL_HOLD;
      case (Mode)
         MODE_SHL, MODE_ROL: sel = SEL_LEFT;
         MODE_SHR, MODE_ROR: sel = SEL_RIGHT;
         MODE_LOAD:          sel = SEL_PAR;
         MODE_CLEAR:         sel = SEL_ZERO;
         default:            sel = SEL_HOLD;
      endcase
   end

   // The chain ends take either the serial input or the wrapped-around tap.
   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [W-1:0] left_src;
      logic [W-1:0] right_src;

      if (k == 0) begin : g_first
         assign left_src = (Mode == MODE_ROL) ? tap[DEPTH-1] : Din;
      end else begin : g_mid_l
         assign left_src = tap[k-1];
      end

      if (k == DEPTH-1) begin : g_last
         assign right_src = (Mode == MODE_ROR) ? tap[0] : Din;
      end else begin : g_mid_r
         assign right_src = tap[k+1];
      end

      shift_stage #(.W(W)) u_stage (
         .CLK   (CLK),
         .RST   (RST),
         .en    (Ce),
         .sel   (sel),
         .left  (left_src),
         .right (right_src),
         .par   (Pin[W*k +: W]),
         .q     (tap[k])
      );

      assign Dout[W*k +: W] = tap[k];
   end

   assign Full  = (Count == CW'(DEPTH));
   assign Empty = (Count == '0);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         Sout  <= '0;
         Count <= '0;
      end else if (Ce) begin
         case (Mode)
            MODE_SHL: begin
               Sout <= tap[DEPTH-1];
               if (!Full) Count <= Count + 1'b1;
            end
            MODE_SHR: begin
               Sout <= tap[0];
               if (!Full) Count <= Count + 1'b1;
            end
            MODE_LOAD:  Count <= CW'(DEPTH);
            MODE_CLEAR: begin
               Sout  <= '0;
               Count <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_register_param.sv
// Self-checking bench for shift_register_param (W=4, DEPTH=8) against a
// queue-based reference model of the tap chain.
module tb_shift_register_param;

   localparam int W     = 4;
   localparam int DEPTH = 8;

   logic                 CLK = 1'b0;
   logic                 RST = 1'b0;
   logic                 Ce = 1'b0;
   logic [2:0]           Mode = 3'd0;
   logic [W-1:0]         Din = '0;
   logic [W*DEPTH-1:0]   Pin = '0;
   logic [W*DEPTH-1:0]   Dout;
   logic [W-1:0]         Sout;
   logic [3:0]           Count;
   logic                 Full;
   logic                 Empty;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: mq[k] is tap k.
   logic [W-1:0] mq [$];
   logic [W-1:0] m_sout;
   int           m_count;

   shift_register_param #(.W(W), .DEPTH(DEPTH)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .Ce    (Ce),
      .Mode  (Mode),
      .Din   (Din),
      .Pin   (Pin),
      .Dout  (Dout),
      .Sout  (Sout),
      .Count (Count),
      .Full  (Full),
      .Empty (Empty)
   );

   always #5 CLK = ~CLK;

   function automatic logic [W*DEPTH-1:0] m_dout();
      logic [W*DEPTH-1:0] r;
      r = '0;
      for (int k = 0; k < DEPTH; k++) r[W*k +: W] = mq[k];
      return r;
   endfunction

   task automatic model_reset();
      mq = {};
      for (int k = 0; k < DEPTH; k++) mq.push_back('0);
      m_sout  = '0;
      m_count = 0;
   endtask

   // Drive one cycle on the falling edge, let the rising edge act, then
   // advance the model and leave the outputs settled for sampling.
   task automatic apply(input logic ce, input logic [2:0] mode,
                        input logic [W-1:0] din, input logic [W*DEPTH-1:0] pin);
      @(negedge CLK);
      Ce = ce; Mode = mode; Din = din; Pin = pin;
      @(posedge CLK);
      #1;
      if (ce) begin
         case (mode)
            3'd1: begin
               mq.push_front(din);
               m_sout = mq.pop_back();
               if (m_count < DEPTH) m_count++;
            end
            3'd2: begin
               mq.push_back(din);
               m_sout = mq.pop_front();
               if (m_count < DEPTH) m_count++;
            end
            3'd3: mq.push_front(mq.pop_back());
            3'd4: mq.push_back(mq.pop_front());
            3'd5: begin
               for (int k = 0; k < DEPTH; k++) mq[k] = pin[W*k +: W];
               m_count = DEPTH;
            end
            3'd6: begin
               for (int k = 0; k < DEPTH; k++) mq[k] = '0;
               m_sout  = '0;
               m_count = 0;
            end
            default: ;
         endcase
      end
   endtask

   task automatic test_reset();
      RST = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      vectors++;
      if (Dout !== '0) begin miscompares++; $display("FAIL reset_dout got %h want 0", Dout); end
      vectors++;
      if (Sout !== '0 || Count !== '0) begin
         miscompares++; $display("FAIL reset_sout_count got %h/%0d want 0/0", Sout, Count);
      end
      vectors++;
      if (Empty !== 1'b1 || Full !== 1'b0) begin
         miscompares++; $display("FAIL reset_flags got empty=%b full=%b want 1/0", Empty, Full);
      end
      @(negedge CLK);
      RST = 1'b1;
   endtask

   task automatic test_fill_and_overflow();
      for (int i = 1; i <= DEPTH; i++) begin
         apply(1'b1, 3'd1, W'(i), '0);
         vectors++;
         if (Dout !== m_dout() || Count !== 4'(m_count)) begin
            miscompares++;
            $display("FAIL fill_step%0d got %h/%0d want %h/%0d", i, Dout, Count, m_dout(), m_count);
         end
      end
      vectors++;
      if (Dout !== 32'h12345678 || Sout !== 4'h0 || Count !== 4'd8 || Full !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_final got %h sout=%h cnt=%0d full=%b want 12345678 0 8 1", Dout, Sout, Count, Full);
      end
      apply(1'b1, 3'd1, 4'h9, '0);
      vectors++;
      if (Dout !== 32'h23456789 || Sout !== 4'h1 || Count !== 4'd8 || Full !== 1'b1) begin
         miscompares++;
         $display("FAIL shl_when_full got %h sout=%h cnt=%0d want 23456789 1 8", Dout, Sout, Count);
      end
   endtask

   task automatic test_load_rotate();
      logic [3:0] sout_before;
      apply(1'b1, 3'd5, '0, 32'h76543210);
      vectors++;
      if (Dout !== 32'h76543210 || Count !== 4'd8 || Sout !== 4'h1) begin
         miscompares++;
         $display("FAIL load got %h cnt=%0d sout=%h want 76543210 8 1", Dout, Count, Sout);
      end
      sout_before = Sout;
      apply(1'b1, 3'd3, 4'hF, '0);
      vectors++;
      if (Dout !== 32'h65432107 || Sout !== sout_before || Count !== 4'd8) begin
         miscompares++;
         $display("FAIL rol_once got %h sout=%h cnt=%0d want 65432107 %h 8", Dout, Sout, Count, sout_before);
      end
      repeat (DEPTH-1) apply(1'b1, 3'd3, 4'hF, '0);
      vectors++;
      if (Dout !== 32'h76543210) begin
         miscompares++; $display("FAIL rol_full_turn got %h want 76543210", Dout);
      end
      apply(1'b1, 3'd4, 4'hF, '0);
      vectors++;
      if (Dout !== 32'h07654321 || Count !== 4'd8) begin
         miscompares++; $display("FAIL ror_once got %h cnt=%0d want 07654321 8", Dout, Count);
      end
   endtask

   task automatic test_ce_hold();
      logic [31:0] d_snap;
      logic [3:0]  s_snap;
      apply(1'b1, 3'd6, '0, '0);
      apply(1'b1, 3'd2, 4'hA, '0);
      vectors++;
      if (Dout !== 32'hA0000000 || Count !== 4'd1 || Empty !== 1'b0 || Full !== 1'b0) begin
         miscompares++;
         $display("FAIL shr_after_clear got %h cnt=%0d empty=%b want A0000000 1 0", Dout, Count, Empty);
      end
      d_snap = Dout;
      s_snap = Sout;
      for (int i = 0; i < 5; i++) begin
         apply(1'b0, 3'd1, 4'h3, 32'hFFFFFFFF);
         vectors++;
         if (Dout !== d_snap || Sout !== s_snap || Count !== 4'd1) begin
            miscompares++;
            $display("FAIL ce_low_hold%0d got %h/%h/%0d want %h/%h/1", i, Dout, Sout, Count, d_snap, s_snap);
         end
      end
   endtask

   task automatic test_reserved_and_clear();
      apply(1'b1, 3'd5, '0, 32'hCAFE1234);
      apply(1'b1, 3'd1, 4'h6, '0);
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 3'd7, 4'hE, 32'h0F0F0F0F);
         vectors++;
         if (Dout !== m_dout() || Sout !== m_sout || Count !== 4'(m_count)) begin
            miscompares++;
            $display("FAIL reserved_hold%0d got %h/%h/%0d want %h/%h/%0d",
                     i, Dout, Sout, Count, m_dout(), m_sout, m_count);
         end
      end
      apply(1'b1, 3'd6, 4'h5, 32'h11111111);
      vectors++;
      if (Dout !== '0 || Sout !== '0 || Count !== '0 || Empty !== 1'b1 || Full !== 1'b0) begin
         miscompares++;
         $display("FAIL clear got %h sout=%h cnt=%0d empty=%b want 0 0 0 1", Dout, Sout, Count, Empty);
      end
   endtask

   task automatic test_random();
      logic [2:0]  mode;
      logic        ce;
      for (int i = 0; i < 400; i++) begin
         mode = 3'($urandom_range(0, 7));
         ce   = ($urandom_range(0, 3) != 0);
         apply(ce, mode, 4'($urandom), $urandom);
         vectors++;
         if (Dout !== m_dout() || Sout !== m_sout || Count !== 4'(m_count) ||
             Full !== (m_count == DEPTH) || Empty !== (m_count == 0)) begin
            miscompares++;
            $display("FAIL random%0d mode=%0d ce=%b got %h/%h/%0d/%b%b want %h/%h/%0d",
                     i, mode, ce, Dout, Sout, Count, Full, Empty, m_dout(), m_sout, m_count);
         end
      end
   endtask

   task automatic test_reset_mid();
      apply(1'b1, 3'd5, '0, 32'h89ABCDEF);
      apply(1'b1, 3'd1, 4'h4, '0);
      @(negedge CLK);
      Ce = 1'b1; Mode = 3'd1; Din = 4'h7;
      #2;
      RST = 1'b0;
      #1;
      model_reset();
      vectors++;
      if (Dout !== '0 || Sout !== '0 || Count !== '0 || Empty !== 1'b1 || Full !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_async got %h sout=%h cnt=%0d empty=%b want 0 0 0 1", Dout, Sout, Count, Empty);
      end
      @(posedge CLK);
      #1;
      vectors++;
      if (Dout !== '0 || Count !== '0) begin
         miscompares++; $display("FAIL reset_held got %h cnt=%0d want 0 0", Dout, Count);
      end
      #2;
      RST = 1'b1;
      apply(1'b1, 3'd1, 4'h5, '0);
      vectors++;
      if (Dout !== 32'h00000005 || Count !== 4'd1 || Sout !== 4'h0 || Empty !== 1'b0) begin
         miscompares++;
         $display("FAIL after_reset_shl got %h cnt=%0d sout=%h want 00000005 1 0", Dout, Count, Sout);
      end
   endtask

   initial begin
      test_reset();
      test_fill_and_overflow();
      test_load_rotate();
      test_ce_hold();
      test_reserved_and_clear();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
